// File: rtl/gt_serial_cmp.sv
// gt_serial_cmp: sequential unsigned magnitude comparator, one 2-bit slice per clock, MSB first.
// Optional feature macro: GT_SERIAL_EARLY_EXIT_EN (stop on the first differing slice).
// Without the macro every compare takes WIDTH/2 cycles (constant time).
module gt_serial_cmp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int S_MAX = WIDTH / 2;
  localparam int IW    = (S_MAX > 1) ? $clog2(S_MAX) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state_reg, state_next;

  // Operands shift left by one slice per cycle so the slice under test is always the top two bits
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg;
  logic [IW-1:0]    idx_reg;
  // Result accumulators: first differing slice wins, later slices cannot overturn it
  logic             gt_acc_reg, lt_acc_reg;
  logic             gt_reg, eq_reg, lt_reg;

  logic [1:0] slice_a, slice_b;
  logic       slice_gt, slice_lt;
  logic       decided, res_gt, res_lt;
  logic       last_slice, finish, accept;

  // Slice compare and completion decision for the current CMP cycle
  always_comb begin
    slice_a    = a_sh_reg[WIDTH-1 -: 2];
    slice_b    = b_sh_reg[WIDTH-1 -: 2];
    slice_gt   = (slice_a > slice_b);
    slice_lt   = (slice_a < slice_b);
    decided    = gt_acc_reg | lt_acc_reg;
    res_gt     = gt_acc_reg | (~decided & slice_gt);
    res_lt     = lt_acc_reg | (~decided & slice_lt);
    last_slice = (idx_reg == '0);
`ifdef GT_SERIAL_EARLY_EXIT_EN
    finish     = last_slice | slice_gt | slice_lt;
`else
    finish     = last_slice;
`endif
    // A request is taken whenever no compare is running, including the done cycle
    accept     = start & (state_reg != ST_CMP);
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_CMP;
      ST_CMP:  if (finish) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_CMP : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode: busy and done are pure functions of the state
  always_comb begin
    busy = (state_reg == ST_CMP);
    done = (state_reg == ST_DONE);
  end

  // Datapath: operand capture, slice walk and result publication at completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      idx_reg    <= '0;
      gt_acc_reg <= 1'b0;
      lt_acc_reg <= 1'b0;
      gt_reg     <= 1'b0;
      eq_reg     <= 1'b0;
      lt_reg     <= 1'b0;
    end else if (accept) begin
      a_sh_reg   <= a;
      b_sh_reg   <= b;
      idx_reg    <= IW'(S_MAX - 1);
      gt_acc_reg <= 1'b0;
      lt_acc_reg <= 1'b0;
      gt_reg     <= 1'b0;
      eq_reg     <= 1'b0;
      lt_reg     <= 1'b0;
    end else if (state_reg == ST_CMP) begin
      a_sh_reg   <= a_sh_reg << 2;
      b_sh_reg   <= b_sh_reg << 2;
      idx_reg    <= idx_reg - IW'(1);
      gt_acc_reg <= res_gt;
      lt_acc_reg <= res_lt;
      // Flags stay clear until the compare completes so no partial result leaks out
      if (finish) begin
        gt_reg <= res_gt;
        lt_reg <= res_lt;
        eq_reg <= ~(res_gt | res_lt);
      end
    end
  end

  assign gt = gt_reg;
  assign eq = eq_reg;
  assign lt = lt_reg;

endmodule

// File: tb/tb_gt_serial_cmp.sv
// Scoreboard bench for gt_serial_cmp: an 8-bit instance with directed and random
// operands, plus a 4-bit instance swept over every operand pair.
module tb_gt_serial_cmp;

`ifdef GT_SERIAL_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef struct {
    int unsigned a;
    int unsigned b;
    logic [2:0]  flags;  // {gt,eq,lt}
    int          lat;
  } txn_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start8 = 1'b0, start4 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic busy8, done8, gt8, eq8, lt8;
  logic busy4, done4, gt4, eq4, lt4;

  int errors = 0;
  int checks = 0;
  txn_t q8[$];
  txn_t q4[$];
  int cnt8 = 0, cnt4 = 0;

  always #5 clk = ~clk;

  gt_serial_cmp #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8)
  );

  gt_serial_cmp #(.WIDTH(4)) u4 (
    .clk(clk), .reset_n(reset_n), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .gt(gt4), .eq(eq4), .lt(lt4)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: cycles = slices examined; early exit stops at the slice holding the top differing bit
  function automatic int model_lat(input int unsigned x, input int unsigned y, input int w);
    int unsigned d;
    int p;
    d = x ^ y;
    p = -1;
    if (!EE || d == 0) return w / 2;
    for (int k = 0; k < w; k++) if (d[k]) p = k;
    return w / 2 - p / 2;
  endfunction

  function automatic logic [2:0] model_flags(input int unsigned x, input int unsigned y);
    if (x > y) return 3'b100;
    if (x == y) return 3'b010;
    return 3'b001;
  endfunction

  // Drive a request on the first negedge where the 8-bit DUT is free; queue its expectation
  task automatic issue8(input int unsigned x, input int unsigned y, output bit was_done);
    txn_t t;
    bit ok = 0;
    was_done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy8) begin ok = 1; break; end
    end
    if (!ok) chk("issue8_timeout", 0, 1);
    was_done = done8;
    a8 = x[7:0]; b8 = y[7:0]; start8 = 1'b1;
    t.a = x; t.b = y; t.flags = model_flags(x, y); t.lat = model_lat(x, y, 8);
    q8.push_back(t);
    @(negedge clk);
    start8 = 1'b0;
  endtask

  task automatic issue4(input int unsigned x, input int unsigned y);
    txn_t t;
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy4) begin ok = 1; break; end
    end
    if (!ok) chk("issue4_timeout", 0, 1);
    a4 = x[3:0]; b4 = y[3:0]; start4 = 1'b1;
    t.a = x; t.b = y; t.flags = model_flags(x, y); t.lat = model_lat(x, y, 4);
    q4.push_back(t);
    @(negedge clk);
    start4 = 1'b0;
  endtask

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy8) begin
        cnt8++;
        chk("flags8_while_busy", int'({gt8, eq8, lt8}), 0);
      end
      if (done8) begin
        if (q8.size() == 0) chk("done8_unexpected", 1, 0);
        else begin
          txn_t t;
          t = q8.pop_front();
          chk("flags8", int'({gt8, eq8, lt8}), int'(t.flags));
          chk("lat8", cnt8, t.lat);
          $display("w8 a=%02h b=%02h gt=%0b eq=%0b lt=%0b cycles=%0d", t.a, t.b, gt8, eq8, lt8, cnt8);
        end
      end
      if (!busy8) cnt8 = 0;
    end
  end

  // Monitor for the 4-bit instance
  always @(negedge clk) begin
    if (reset_n) begin
      if (busy4) begin
        cnt4++;
        chk("flags4_while_busy", int'({gt4, eq4, lt4}), 0);
      end
      if (done4) begin
        if (q4.size() == 0) chk("done4_unexpected", 1, 0);
        else begin
          txn_t t;
          t = q4.pop_front();
          chk("flags4", int'({gt4, eq4, lt4}), int'(t.flags));
          chk("lat4", cnt4, t.lat);
          $display("w4 a=%01h b=%01h gt=%0b eq=%0b lt=%0b cycles=%0d", t.a, t.b, gt4, eq4, lt4, cnt4);
        end
      end
      if (!busy4) cnt4 = 0;
    end
  end

  initial begin
    bit wd;
    // Reset state
    #12;
    chk("rst_outputs8", int'({busy8, done8, gt8, eq8, lt8}), 0);
    chk("rst_outputs4", int'({busy4, done4, gt4, eq4, lt4}), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Directed: one-LSB difference, MSB difference
    issue8(32'hA5, 32'hA4, wd);
    issue8(32'h80, 32'h7F, wd);

    // Equal then back-to-back request in the done cycle
    issue8(32'h3C, 32'h3C, wd);
    issue8(32'h01, 32'h02, wd);
    chk("b2b_in_done_cycle", int'(wd), 1);

    // Start while busy must be ignored
    issue8(32'h10, 32'h20, wd);
    a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
    chk("busy_during_restart", int'(busy8), 1);
    @(negedge clk);
    start8 = 1'b0;

    // Asynchronous reset mid-compare aborts the transaction
    issue8(32'h3C, 32'h3C, wd);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #0.5;
    chk("async_rst_clears", int'({busy8, done8, gt8, eq8, lt8}), 0);
    #0.5 reset_n = 1'b1;
    q8.delete();
    issue8(32'h55, 32'h56, wd);

    // Randomised operands with random idle gaps
    for (int n = 0; n < 150; n++) begin
      int unsigned x, y;
      x = $urandom_range(0, 255);
      y = ($urandom_range(0, 3) == 0) ? x : $urandom_range(0, 255);
      issue8(x, y, wd);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Exhaustive 4-bit sweep, loop counters wider than the operands
    for (logic [4:0] i = 0; i < 16; i++)
      for (logic [4:0] j = 0; j < 16; j++)
        issue4(int'(i), int'(j));

    // Drain with a bound
    begin
      bit drained = 0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        if (q8.size() == 0 && q4.size() == 0 && !busy8 && !busy4) begin drained = 1; break; end
      end
      chk("drain", int'(drained), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
